// File: rtl/sha3_msg_arbiter_pkg.sv
// Shared types and default sizing for the SHA3 message arbiter.
package sha3_msg_arbiter_pkg;

    // Default requester count, beat width and digest length (SHA3-256).
    localparam int DEF_N_REQ        = 4;
    localparam int DEF_DATA_W       = 64;
    localparam int DEF_DIGEST_WORDS = 4;

    // Message-level arbitration phases.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ABSORB  = 2'd1,
        SQUEEZE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sha3_msg_arbiter_if.sv
// Handshake bundle between the requester fabric, the arbiter and the SHA3 core.
// The master view belongs to the arbiter; the slave view is the surrounding
// environment (requesters plus the core's TB-side handshake).
interface sha3_msg_arbiter_if
    import sha3_msg_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W
);

    // Requester-facing absorb stream
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_done;
    logic [N_REQ-1:0]        req_ready;

    // Requester-facing digest stream
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [N_REQ-1:0]        rsp_ready;

    // Core absorb side
    logic                    sha3_in_valid;
    logic [DATA_W-1:0]       sha3_in_data;
    logic                    sha3_in_done;
    logic                    sha3_in_ready;

    // Core squeeze side and status
    logic                    sha3_out_valid;
    logic [DATA_W-1:0]       sha3_out_data;
    logic                    sha3_out_ready;
    logic                    sha3_busy;

    modport master (
        input  req_valid, req_data, req_done, rsp_ready,
        input  sha3_in_ready, sha3_out_valid, sha3_out_data, sha3_busy,
        output req_ready, rsp_valid, rsp_data,
        output sha3_in_valid, sha3_in_data, sha3_in_done, sha3_out_ready
    );

    modport slave (
        output req_valid, req_data, req_done, rsp_ready,
        output sha3_in_ready, sha3_out_valid, sha3_out_data, sha3_busy,
        input  req_ready, rsp_valid, rsp_data,
        input  sha3_in_valid, sha3_in_data, sha3_in_done, sha3_out_ready
    );

endinterface

// File: rtl/sha3_msg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans req starting at ptr and wrapping,
// returning the first hit as both a one-hot vector and an index.
module sha3_msg_arbiter_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] scan;

    // Walk ptr, ptr+1, ... (mod N) and latch the first requester seen.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        scan      = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any && req[scan]) begin
                any         = 1'b1;
                grant[scan] = 1'b1;
                grant_idx   = scan;
            end
            scan = (scan == IDX_W'(N - 1)) ? '0 : scan + 1'b1;
        end
    end

endmodule

// File: rtl/sha3_msg_arbiter.sv
// Shares one SHA3 core among N_REQ requesters one whole message at a time:
// grant, pass the absorb stream through, return DIGEST_WORDS digest beats to
// the same requester, then re-arbitrate round-robin from the next requester.
module sha3_msg_arbiter
    import sha3_msg_arbiter_pkg::*;
#(
    parameter  int N_REQ        = DEF_N_REQ,
    parameter  int DATA_W       = DEF_DATA_W,
    parameter  int DIGEST_WORDS = DEF_DIGEST_WORDS,
    localparam int GNT_W        = $clog2(N_REQ),
    localparam int BEAT_W       = $clog2(DIGEST_WORDS) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sha3_msg_arbiter_if.master   bus,
    output logic [GNT_W-1:0]     grant_id,
    output logic                 active,
    output logic                 err_spurious
);

    arb_state_t        state_q,    state_d;
    logic [GNT_W-1:0]  grant_q,    grant_d;
    logic [N_REQ-1:0]  gnt_oh_q,   gnt_oh_d;
    logic [GNT_W-1:0]  rr_ptr_q,   rr_ptr_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              err_q,      err_d;

    logic [N_REQ-1:0]  arb_oh;
    logic [GNT_W-1:0]  arb_idx;
    logic              arb_any;

    logic              in_vld;
    logic              in_done;
    logic              out_rdy;

    sha3_msg_arbiter_rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req       (bus.req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // State, grant, round-robin pointer, digest beat counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gnt_oh_q   <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gnt_oh_q   <= gnt_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic and stream routing for the granted requester.
    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        gnt_oh_d           = gnt_oh_q;
        rr_ptr_d           = rr_ptr_q;
        beat_cnt_d         = beat_cnt_q;
        err_d              = err_q;
        in_vld             = 1'b0;
        in_done            = 1'b0;
        out_rdy            = 1'b0;
        bus.req_ready      = '0;
        bus.rsp_valid      = '0;
        bus.rsp_data       = '0;
        bus.sha3_in_valid  = 1'b0;
        bus.sha3_in_data   = '0;
        bus.sha3_in_done   = 1'b0;
        bus.sha3_out_ready = 1'b0;

        case (state_q)
            IDLE: begin
                // A busy core is still finishing someone else's work; hold off.
                if (arb_any && !bus.sha3_busy) begin
                    grant_d  = arb_idx;
                    gnt_oh_d = arb_oh;
                    state_d  = ABSORB;
                end
            end

            ABSORB: begin
                in_vld            = bus.req_valid[grant_q];
                in_done           = bus.req_done[grant_q];
                bus.sha3_in_valid = in_vld;
                bus.sha3_in_data  = bus.req_data[grant_q*DATA_W +: DATA_W];
                bus.sha3_in_done  = in_done;
                bus.req_ready     = gnt_oh_q & {N_REQ{bus.sha3_in_ready}};
                // A requester that stalls mid-message keeps the grant.
                if (in_vld && bus.sha3_in_ready && in_done) begin
                    state_d    = SQUEEZE;
                    beat_cnt_d = '0;
                end
            end

            SQUEEZE: begin
                out_rdy            = bus.rsp_ready[grant_q];
                bus.rsp_valid      = gnt_oh_q & {N_REQ{bus.sha3_out_valid}};
                bus.rsp_data       = bus.sha3_out_data;
                bus.sha3_out_ready = out_rdy;
                if (bus.sha3_out_valid && out_rdy) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(DIGEST_WORDS - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (grant_q == GNT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        // Digest output with nobody waiting for it means the core and the
        // arbiter disagree about message boundaries.
        if (state_q != SQUEEZE && bus.sha3_out_valid) begin
            err_d = 1'b1;
        end
    end

    assign grant_id     = grant_q;
    assign active       = (state_q != IDLE);
    assign err_spurious = err_q;

endmodule

// File: tb/tb_sha3_msg_arbiter.sv
// Directed bench for sha3_msg_arbiter; the bench plays both the requesters
// and the SHA3 core handshake.
module tb_sha3_msg_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       active;
    logic       err_spurious;

    int n_cmp = 0;
    int n_err = 0;

    sha3_msg_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    sha3_msg_arbiter #(
        .N_REQ        (N),
        .DATA_W       (DW),
        .DIGEST_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .grant_id     (grant_id),
        .active       (active),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int r);
        logic [N-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'h0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'h0);
        chk({tag, "_rsp_data"}, bus.rsp_data, 64'h0);
        chk({tag, "_in_valid"}, 64'(bus.sha3_in_valid), 64'h0);
        chk({tag, "_in_data"}, bus.sha3_in_data, 64'h0);
        chk({tag, "_in_done"}, 64'(bus.sha3_in_done), 64'h0);
        chk({tag, "_out_ready"}, 64'(bus.sha3_out_ready), 64'h0);
        chk({tag, "_active"}, 64'(active), 64'h0);
    endtask

    task automatic wait_grant(input int r);
        for (int i = 0; i < 8 && !active; i++) tick();
        chk("grant_active", 64'(active), 64'h1);
        chk("grant_id", 64'(grant_id), 64'(r));
    endtask

    // Present nbeats beats from requester r (optionally one stall cycle each).
    task automatic absorb(input int r, input int nbeats, input logic [63:0] base, input bit stall);
        for (int b = 0; b < nbeats; b++) begin
            bus.req_valid[r]          = 1'b1;
            bus.req_data[r*DW +: DW]  = base + 64'(b);
            bus.req_done[r]           = (b == nbeats - 1);
            if (stall) begin
                bus.sha3_in_ready = 1'b0;
                #1;
                chk("abs_stall_ready", 64'(bus.req_ready), 64'h0);
                chk("abs_stall_valid", 64'(bus.sha3_in_valid), 64'h1);
                tick();
                bus.sha3_in_ready = 1'b1;
            end
            #1;
            chk("abs_req_ready", 64'(bus.req_ready), 64'(onehot(r)));
            chk("abs_in_valid", 64'(bus.sha3_in_valid), 64'h1);
            chk("abs_in_data", bus.sha3_in_data, base + 64'(b));
            chk("abs_in_done", 64'(bus.sha3_in_done), 64'(b == nbeats - 1));
            tick();
        end
        bus.req_done[r] = 1'b0;
    endtask

    // Deliver 4 digest beats to requester r; with toggle, rsp_ready[r] alternates 0/1.
    task automatic squeeze(input int r, input logic [63:0] base, input bit toggle);
        int  hs;
        bit  ph;
        logic rr;
        hs = 0;
        ph = 1'b0;
        for (int cyc = 0; cyc < 40 && hs < 4; cyc++) begin
            rr                 = toggle ? ph : 1'b1;
            bus.sha3_out_valid = 1'b1;
            bus.sha3_out_data  = base + 64'(hs);
            bus.rsp_ready      = '1;
            bus.rsp_ready[r]   = rr;
            #1;
            chk("sq_out_ready", 64'(bus.sha3_out_ready), 64'(rr));
            chk("sq_rsp_valid", 64'(bus.rsp_valid), 64'(onehot(r)));
            chk("sq_rsp_data", bus.rsp_data, base + 64'(hs));
            chk("sq_in_valid", 64'(bus.sha3_in_valid), 64'h0);
            chk("sq_req_ready", 64'(bus.req_ready), 64'h0);
            tick();
            if (rr) hs++;
            ph = ~ph;
        end
        bus.sha3_out_valid = 1'b0;
        bus.rsp_ready      = '1;
        #1;
        chk("sq_handshakes", 64'(hs), 64'd4);
        chk("sq_back_idle", 64'(active), 64'h0);
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.req_valid      = '0;
        bus.req_done       = '0;
        bus.rsp_ready      = '1;
        bus.sha3_in_ready  = 1'b1;
        bus.sha3_out_valid = 1'b0;
        bus.sha3_out_data  = 64'h0;
        bus.sha3_busy      = 1'b0;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = 64'hFFFF_0000_0000_0000 | 64'(i);

        // Reset values
        repeat (3) tick();
        chk_all_zero("rst");
        chk("rst_grant_id", 64'(grant_id), 64'h0);
        chk("rst_err", 64'(err_spurious), 64'h0);
        rst_n = 1'b1;
        tick();

        // All four requesting, 3-beat messages: grants 0,1,2,3,0
        bus.req_valid = '1;
        for (int m = 0; m < 5; m++) begin
            wait_grant(m % 4);
            absorb(m % 4, 3, 64'h1000_0000 + 64'(m * 16), 1'b0);
            squeeze(m % 4, 64'hD000 + 64'(m * 16), 1'b0);
        end
        bus.req_valid = '0;
        tick();

        // Reset while requester 0 is on beat 2
        bus.req_valid = 4'b0001;
        wait_grant(0);
        bus.req_valid             = 4'b0011;
        bus.req_data[0*DW +: DW]  = 64'hB0;
        tick();
        bus.req_data[0*DW +: DW]  = 64'hB1;
        tick();
        bus.req_data[0*DW +: DW]  = 64'hB2;
        #1;
        chk("mid_beat2_data", bus.sha3_in_data, 64'hB2);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        chk("mid_rst_grant_id", 64'(grant_id), 64'h0);
        tick();
        chk_all_zero("mid_rst_hold");
        rst_n = 1'b1;
        wait_grant(0);
        absorb(0, 1, 64'hC0, 1'b0);
        squeeze(0, 64'hE000, 1'b0);
        bus.req_valid = '0;
        tick();

        // Requester 2 alone, single-beat message
        bus.req_valid = 4'b0100;
        wait_grant(2);
        absorb(2, 1, 64'hA5, 1'b0);
        bus.req_valid = '0;
        squeeze(2, 64'hF200, 1'b0);

        // Busy core blocks the grant
        bus.sha3_busy = 1'b1;
        bus.req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_active", 64'(active), 64'h0);
            chk("busy_req_ready", 64'(bus.req_ready), 64'h0);
            chk("busy_grant_id", 64'(grant_id), 64'h2);
        end
        bus.sha3_busy = 1'b0;
        #1;
        chk("busy_drop_active", 64'(active), 64'h0);
        wait_grant(1);
        absorb(1, 2, 64'h7700, 1'b1);
        bus.req_valid = '0;
        squeeze(1, 64'h5100, 1'b1);

        // Spurious core output in IDLE
        chk("spur_err_before", 64'(err_spurious), 64'h0);
        bus.sha3_out_valid = 1'b1;
        bus.sha3_out_data  = 64'hDEAD;
        bus.req_valid      = 4'b1000;
        #1;
        chk("spur_out_ready", 64'(bus.sha3_out_ready), 64'h0);
        chk("spur_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        tick();
        bus.sha3_out_valid = 1'b0;
        #1;
        chk("spur_err_set", 64'(err_spurious), 64'h1);
        wait_grant(3);
        absorb(3, 2, 64'h3300, 1'b0);
        bus.req_valid = '0;
        squeeze(3, 64'h3D00, 1'b0);
        chk("spur_err_sticky", 64'(err_spurious), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
